pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Program-counter sequencer for the RV32I core. It owns the PC register, issues fetch requests to instruction memory with a ready handshake, and applies redirects from the execute-stage branch/jump comparator. On a redirect it asserts a multi-cycle pipeline flush. It sits between the fetch stage, the execute stage's jump flag/target outputs and the hazard unit's stall line.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- TRAP_VEC, 32'h0000_0100, PC loaded on a misaligned redirect target.
- FLUSH_CYCLES, 2, number of cycles `flush` is held after a redirect (legal range 1..7).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- stall  in  1  hazard unit hold request.
- ex_valid  in  1  execute stage holds a valid instruction.
- jump_flag  in  1  execute stage requests a redirect; only meaningful when ex_valid=1.
- jump_target  in  32  redirect target address.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address; equals pc.
- imem_ready  in  1  instruction memory accepts the request in this cycle.
- pc  out  32  current PC register.
- flush  out  1  kill signal for younger pipeline stages.
- misalign  out  1  one-cycle pulse when a redirect target has bits [1:0] not equal to 0.
- redirect_cnt  out  32  count of accepted redirects; wraps modulo 2^32.

## Operation
- Reset values:
  - State BOOT.
  - pc = RESET_PC.
  - imem_req = 0, flush = 0, misalign = 0.
  - redirect_cnt = 0.
  - Flush counter = 0.
- States and transitions:
  - BOOT: imem_req = 0. Goes to FETCH unconditionally on the next edge.
  - FETCH: imem_req = !stall. If imem_req and imem_ready are both 1, pc <= pc + 4 (wraps modulo 2^32).
  - FLUSH: imem_req = 0 and flush = 1. The counter decrements each cycle; the state returns to FETCH in the cycle after the counter reaches 1.
- Redirect accepted: ex_valid & jump_flag while in FETCH. In that case:
  - pc <= {jump_target[31:2], 2'b00}. If jump_target[1:0] != 0, pc <= TRAP_VEC instead and misalign pulses in the next cycle.
  - Enter FLUSH with the counter set to FLUSH_CYCLES.
  - redirect_cnt increments by 1.
- Priority within FETCH: redirect > stall > sequential advance. A redirect is accepted even while stall=1. A redirect coincident with an imem handshake discards the pc + 4 update.
- Redirect requests in BOOT or FLUSH are ignored. The execute stage is being flushed at those times, and redirect_cnt does not change.
- Stall with no redirect: pc is held and imem_req = 0, so no handshake is possible.
- imem_ready without imem_req has no effect.
- Reset asserted mid-operation (including mid-FLUSH): all state returns immediately to the reset values. The flush in progress is abandoned.

## Timing
- pc, state, counter, misalign and redirect_cnt are registered.
- imem_req, imem_addr and flush are combinational from registered state plus stall. No combinational path runs from jump_flag to imem_req.
- Redirect latency:
  - jump_flag sampled at edge N.
  - New pc visible after edge N.
  - flush high in cycles N+1 .. N+FLUSH_CYCLES.
  - First fetch of the target in cycle N+FLUSH_CYCLES+1.
- Sequential fetch throughput: one instruction per cycle while imem_ready = 1 and stall = 0.
- misalign is high for exactly one cycle, coincident with the first flush cycle.

## Test plan
- Reset then run: release rst_n, hold imem_ready = 1 and stall = 0.
  - Required: imem_req = 0 in the first cycle (BOOT).
  - Required: imem_addr then reads 0x0, 0x4, 0x8, 0xC on consecutive cycles.
- Backpressure: imem_ready = 0 for 3 cycles at pc = 0x10.
  - Required: pc stays at 0x10 with imem_req = 1.
  - Required: pc advances to 0x14 on the first cycle with imem_ready = 1.
- Redirect: at pc = 0x20, pulse ex_valid = jump_flag = 1 with jump_target = 0x80, FLUSH_CYCLES = 2.
  - Required: flush = 1 for exactly 2 cycles with imem_req = 0.
  - Required: next fetch address is 0x80; redirect_cnt = 1.
- Redirect during stall and during flush:
  - Redirect to 0x40 with stall = 1: accepted, pc = 0x40.
  - Second redirect to 0x60 in the first flush cycle: ignored; pc stays 0x40 and redirect_cnt increments only once.
- Misaligned target: jump_target = 0x102.
  - Required: pc = TRAP_VEC (0x100).
  - Required: misalign high for exactly one cycle, coincident with the first flush cycle.
- Reset mid-flush: assert rst_n = 0 in the first flush cycle.
  - Required: pc = RESET_PC, flush = 0 and redirect_cnt = 0 immediately, without waiting for a clock edge.
  - Required: BOOT then FETCH from RESET_PC after release.

Source files
------------

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: owns the PC, issues fetch requests with a ready
// handshake and applies execute-stage redirects followed by a timed pipeline flush.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC     = 32'h0000_0100,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        ex_valid,
  input  logic        jump_flag,
  input  logic [31:0] jump_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  output logic [31:0] pc,
  output logic        flush,
  output logic        misalign,
  output logic [31:0] redirect_cnt
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES);

  state_t      state, state_next;
  logic [2:0]  flush_cnt, flush_cnt_next;
  logic [31:0] pc_next;
  logic [31:0] redirect_cnt_next;
  logic        misalign_next;

  // Misaligned targets trap instead of fetching from a half-word address.
  function automatic logic [31:0] redirect_pc(input logic [31:0] target);
    return (target[1:0] != 2'b00) ? TRAP_VEC : {target[31:2], 2'b00};
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= BOOT;
      pc           <= RESET_PC;
      flush_cnt    <= 3'd0;
      misalign     <= 1'b0;
      redirect_cnt <= 32'd0;
    end else begin
      state        <= state_next;
      pc           <= pc_next;
      flush_cnt    <= flush_cnt_next;
      misalign     <= misalign_next;
      redirect_cnt <= redirect_cnt_next;
    end
  end

  always_comb begin
    state_next        = state;
    pc_next           = pc;
    flush_cnt_next    = flush_cnt;
    redirect_cnt_next = redirect_cnt;
    misalign_next     = 1'b0;
    imem_req          = 1'b0;
    flush             = 1'b0;
    case (state)
      BOOT: begin
        state_next = FETCH;
      end
      FETCH: begin
        imem_req = !stall;
        // A redirect wins over both stall and a coincident handshake.
        if (ex_valid && jump_flag) begin
          pc_next           = redirect_pc(jump_target);
          misalign_next     = (jump_target[1:0] != 2'b00);
          flush_cnt_next    = FLUSH_INIT;
          redirect_cnt_next = redirect_cnt + 32'd1;
          state_next        = FLUSH;
        end else if (!stall && imem_ready) begin
          pc_next = pc + 32'd4;
        end
      end
      FLUSH: begin
        flush          = 1'b1;
        flush_cnt_next = flush_cnt - 3'd1;
        if (flush_cnt <= 3'd1) begin
          state_next = FETCH;
        end
      end
      default: begin
        state_next = BOOT;
      end
    endcase
  end

  assign imem_addr = pc;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed vector table, reset-mid-flush sequence and
// randomized traffic against a cycle-level behavioural model.
module tb_pc_sequencer;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] TRAP_VEC = 32'h0000_0100;
  localparam int          FC       = 2;

  logic        clk = 1'b0;
  logic        rst_n, stall, ex_valid, jump_flag, imem_ready;
  logic [31:0] jump_target;
  logic        imem_req, flush, misalign;
  logic [31:0] imem_addr, pc, redirect_cnt;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pc_sequencer #(
    .RESET_PC    (RESET_PC),
    .TRAP_VEC    (TRAP_VEC),
    .FLUSH_CYCLES(FC)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
    .ex_valid    (ex_valid),
    .jump_flag   (jump_flag),
    .jump_target (jump_target),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .pc          (pc),
    .flush       (flush),
    .misalign    (misalign),
    .redirect_cnt(redirect_cnt)
  );

  typedef struct {
    logic        stall, ev, jf;
    logic [31:0] tgt;
    logic        rdy;
    logic        req;
    logic [31:0] addr;
    logic        fl, mis;
    logic [31:0] cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic s, logic e, logic j, logic [31:0] t, logic r,
                              logic q, logic [31:0] a, logic f, logic m, logic [31:0] c);
    vec_t v;
    v.stall = s; v.ev = e; v.jf = j; v.tgt = t; v.rdy = r;
    v.req = q; v.addr = a; v.fl = f; v.mis = m; v.cnt = c;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Behavioural model: boot flag, remaining flush cycles, and architectural values.
  logic        m_boot;
  int          m_fl;
  logic [31:0] m_pc, m_cnt;
  logic        m_mis;

  task automatic model_reset();
    m_boot = 1'b1; m_fl = 0; m_pc = RESET_PC; m_cnt = 0; m_mis = 1'b0;
  endtask

  task automatic model_edge();
    logic mis_n;
    mis_n = 1'b0;
    if (m_boot) m_boot = 1'b0;
    else if (m_fl > 0) m_fl = m_fl - 1;
    else if (ex_valid && jump_flag) begin
      if (jump_target % 4 != 0) begin
        m_pc = TRAP_VEC;
        mis_n = 1'b1;
      end else m_pc = jump_target;
      m_fl = FC;
      m_cnt = m_cnt + 1;
    end else if (!stall && imem_ready) m_pc = m_pc + 4;
    m_mis = mis_n;
  endtask

  task automatic model_check(input string tag);
    chk({tag, "_req"}, 32'(imem_req), 32'(!m_boot && m_fl == 0 && !stall));
    chk({tag, "_addr"}, imem_addr, m_pc);
    chk({tag, "_pc"}, pc, m_pc);
    chk({tag, "_flush"}, 32'(flush), 32'(m_fl > 0));
    chk({tag, "_mis"}, 32'(misalign), 32'(m_mis));
    chk({tag, "_cnt"}, redirect_cnt, m_cnt);
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; ex_valid = 1'b0; jump_flag = 1'b0;
    jump_target = 32'd0; imem_ready = 1'b1;
    tick(); tick();
    chk("rst_pc", pc, RESET_PC);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_flush", 32'(flush), 32'd0);
    chk("rst_mis", 32'(misalign), 32'd0);
    chk("rst_cnt", redirect_cnt, 32'd0);

    // Directed test-plan walk: each row is inputs for a cycle and outputs expected in it.
    vecs.push_back(mk(0,0,0,32'h0,  1, 0,32'h00,0,0,0));
    vecs.push_back(mk(0,0,0,32'h0,  1, 1,32'h00,0,0,0));
    vecs.push_back(mk(0,0,0,32'h0,  1, 1,32'h04,0,0,0));
    vecs.push_back(mk(0,0,0,32'h0,  1, 1,32'h08,0,0,0));
    vecs.push_back(mk(0,0,0,32'h0,  1, 1,32'h0C,0,0,0));
    vecs.push_back(mk(0,0,0,32'h0,  0, 1,32'h10,0,0,0));
    vecs.push_back(mk(0,0,0,32'h0,  0, 1,32'h10,0,0,0));
    vecs.push_back(mk(0,0,0,32'h0,  0, 1,32'h10,0,0,0));
    vecs.push_back(mk(0,0,0,32'h0,  1, 1,32'h10,0,0,0));
    vecs.push_back(mk(0,0,0,32'h0,  1, 1,32'h14,0,0,0));
    vecs.push_back(mk(0,0,0,32'h0,  1, 1,32'h18,0,0,0));
    vecs.push_back(mk(0,0,0,32'h0,  1, 1,32'h1C,0,0,0));
    vecs.push_back(mk(0,1,1,32'h80, 1, 1,32'h20,0,0,0));
    vecs.push_back(mk(0,0,0,32'h0,  1, 0,32'h80,1,0,1));
    vecs.push_back(mk(0,0,0,32'h0,  1, 0,32'h80,1,0,1));
    vecs.push_back(mk(0,0,0,32'h0,  1, 1,32'h80,0,0,1));
    vecs.push_back(mk(1,1,1,32'h40, 1, 0,32'h84,0,0,1));
    vecs.push_back(mk(0,1,1,32'h60, 1, 0,32'h40,1,0,2));
    vecs.push_back(mk(0,0,0,32'h0,  1, 0,32'h40,1,0,2));
    vecs.push_back(mk(0,1,1,32'h102,1, 1,32'h40,0,0,2));
    vecs.push_back(mk(0,0,0,32'h0,  1, 0,32'h100,1,1,3));
    vecs.push_back(mk(0,0,0,32'h0,  1, 0,32'h100,1,0,3));
    vecs.push_back(mk(0,0,0,32'h0,  1, 1,32'h100,0,0,3));
    vecs.push_back(mk(0,0,0,32'h0,  1, 1,32'h104,0,0,3));

    rst_n = 1'b1;
    foreach (vecs[i]) begin
      stall = vecs[i].stall; ex_valid = vecs[i].ev; jump_flag = vecs[i].jf;
      jump_target = vecs[i].tgt; imem_ready = vecs[i].rdy;
      #1;
      chk($sformatf("vec%0d_req", i), 32'(imem_req), 32'(vecs[i].req));
      chk($sformatf("vec%0d_addr", i), imem_addr, vecs[i].addr);
      chk($sformatf("vec%0d_flush", i), 32'(flush), 32'(vecs[i].fl));
      chk($sformatf("vec%0d_mis", i), 32'(misalign), 32'(vecs[i].mis));
      chk($sformatf("vec%0d_cnt", i), redirect_cnt, vecs[i].cnt);
      tick();
    end

    // Reset asserted in the first flush cycle must clear state without a clock edge.
    stall = 1'b0; ex_valid = 1'b1; jump_flag = 1'b1; jump_target = 32'h200; imem_ready = 1'b1;
    tick();
    ex_valid = 1'b0; jump_flag = 1'b0;
    #1;
    chk("midflush_flush", 32'(flush), 32'd1);
    chk("midflush_pc", pc, 32'h200);
    rst_n = 1'b0;
    #1;
    chk("async_rst_pc", pc, RESET_PC);
    chk("async_rst_flush", 32'(flush), 32'd0);
    chk("async_rst_cnt", redirect_cnt, 32'd0);
    chk("async_rst_req", 32'(imem_req), 32'd0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("post_rst_boot_req", 32'(imem_req), 32'd0);
    chk("post_rst_boot_addr", imem_addr, RESET_PC);
    tick();
    chk("post_rst_fetch_req", 32'(imem_req), 32'd1);
    chk("post_rst_fetch_addr", imem_addr, RESET_PC);

    // Randomized traffic, including occasional asynchronous resets.
    rst_n = 1'b0;
    tick();
    model_reset();
    for (int n = 0; n < 600; n++) begin
      rst_n       = ($urandom % 50) != 0;
      stall       = ($urandom % 4) == 0;
      imem_ready  = ($urandom % 3) != 0;
      ex_valid    = ($urandom % 3) == 0;
      jump_flag   = ($urandom % 2) == 0;
      jump_target = $urandom;
      if ($urandom % 2 == 0) jump_target[1:0] = 2'b00;
      #1;
      if (!rst_n) model_reset();
      model_check("rnd");
      tick();
      if (rst_n) model_edge();
      else model_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
